// File: rtl/mdio_controller_if.sv
// Host/PHY-facing signal bundle for mdio_controller.
// The slave modport is the controller, the master modport is its environment.
interface mdio_controller_if;
    logic        MDIO_START;
    logic [31:0] T_DATA;
    logic        MDIO_IN;
    logic        MDC;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic [15:0] RD_DATA;
    logic        DATA_RDY;
    logic        BUSY;

    modport master (
        output MDIO_START,
        output T_DATA,
        output MDIO_IN,
        input  MDC,
        input  MDIO_OUT,
        input  MDIO_OE,
        input  RD_DATA,
        input  DATA_RDY,
        input  BUSY
    );

    modport slave (
        input  MDIO_START,
        input  T_DATA,
        input  MDIO_IN,
        output MDC,
        output MDIO_OUT,
        output MDIO_OE,
        output RD_DATA,
        output DATA_RDY,
        output BUSY
    );
endinterface

// File: rtl/mdio_controller.sv
// Clause-22 MDIO station: one 32-bit frame per request, MDC = CLK/(2*DIV_HALF).
// Define MDIO_PREAMBLE_EN to send 32 preamble ones before every frame.
module mdio_controller #(
    parameter int DIV_HALF = 2
) (
    input logic              CLK,
    input logic              RESET,
    mdio_controller_if.slave bus
);
    localparam logic [7:0] DIV_LAST = 8'(DIV_HALF - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
`ifdef MDIO_PREAMBLE_EN
        PREAMBLE = 2'd1,
`endif
        FRAME    = 2'd2,
        DONE     = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  div_q, div_d;
    logic        mdc_q, mdc_d;
    logic        out_q, out_d;
    logic        oe_q, oe_d;
    logic [31:0] sh_q, sh_d;
    logic        rd_q, rd_d;
    logic [15:0] cap_q, cap_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        rdy_q, rdy_d;
    logic        busy_q, busy_d;

    logic        tick;
    logic [4:0]  nxt;
    logic        drive;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        mdc_d     = mdc_q;
        out_d     = out_q;
        oe_d      = oe_q;
        sh_d      = sh_q;
        rd_d      = rd_q;
        cap_d     = cap_q;
        rd_data_d = rd_data_q;
        rdy_d     = 1'b0;
        busy_d    = busy_q;
        tick      = (div_q == DIV_LAST);
        nxt       = cnt_q - 5'd1;
        // read frames release the bus from the turnaround onward
        drive     = !(rd_q && (nxt <= 5'd17));
        unique case (state_q)
            IDLE: begin
                mdc_d = 1'b0;
                oe_d  = 1'b0;
                out_d = 1'b0;
                div_d = 8'd0;
                cnt_d = 5'd31;
                if (bus.MDIO_START) begin
                    sh_d   = bus.T_DATA;
                    rd_d   = (bus.T_DATA[29:28] == 2'b10);
                    busy_d = 1'b1;
                    oe_d   = 1'b1;
`ifdef MDIO_PREAMBLE_EN
                    state_d = PREAMBLE;
                    out_d   = 1'b1;
`else
                    state_d = FRAME;
                    out_d   = bus.T_DATA[31];
`endif
                end
            end
`ifdef MDIO_PREAMBLE_EN
            PREAMBLE: begin
                div_d = tick ? 8'd0 : div_q + 8'd1;
                if (tick) begin
                    mdc_d = !mdc_q;
                    if (mdc_q) begin
                        if (cnt_q == 5'd0) begin
                            state_d = FRAME;
                            cnt_d   = 5'd31;
                            out_d   = sh_q[31];
                        end else begin
                            cnt_d = nxt;
                        end
                    end
                end
            end
`endif
            FRAME: begin
                div_d = tick ? 8'd0 : div_q + 8'd1;
                if (tick) begin
                    mdc_d = !mdc_q;
                    if (!mdc_q) begin
                        if (rd_q && (cnt_q <= 5'd15))
                            cap_d = {cap_q[14:0], bus.MDIO_IN};
                    end else if (cnt_q == 5'd0) begin
                        state_d = DONE;
                        oe_d    = 1'b0;
                        out_d   = 1'b0;
                    end else begin
                        cnt_d = nxt;
                        oe_d  = drive;
                        out_d = drive & sh_q[nxt];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                div_d   = 8'd0;
                cnt_d   = 5'd31;
                if (rd_q) begin
                    rd_data_d = cap_q;
                    rdy_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd31;
            div_q     <= 8'd0;
            mdc_q     <= 1'b0;
            out_q     <= 1'b0;
            oe_q      <= 1'b0;
            sh_q      <= 32'd0;
            rd_q      <= 1'b0;
            cap_q     <= 16'd0;
            rd_data_q <= 16'd0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            mdc_q     <= mdc_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
            sh_q      <= sh_d;
            rd_q      <= rd_d;
            cap_q     <= cap_d;
            rd_data_q <= rd_data_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.MDC      = mdc_q;
    assign bus.MDIO_OUT = out_q;
    assign bus.MDIO_OE  = oe_q;
    assign bus.RD_DATA  = rd_data_q;
    assign bus.DATA_RDY = rdy_q;
    assign bus.BUSY     = busy_q;
endmodule

// File: tb/tb_mdio_controller.sv
// Bench for mdio_controller: three dividers, frame bits rebuilt from the frame
// layout, a PHY model feeding read data, and busy/reset/timing checks.
module tb_mdio_controller;
`ifdef MDIO_PREAMBLE_EN
    localparam int PRE = 32;
`else
    localparam int PRE = 0;
`endif

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    logic [2:0]  start_v;
    logic [31:0] td_v [3];
    logic        mdio_in;
    logic [15:0] rd_m [3];
    int          sel = 0;

    mdio_controller_if b0 ();
    mdio_controller_if b1 ();
    mdio_controller_if b2 ();

    assign b0.MDIO_START = start_v[0];
    assign b1.MDIO_START = start_v[1];
    assign b2.MDIO_START = start_v[2];
    assign b0.T_DATA = td_v[0];
    assign b1.T_DATA = td_v[1];
    assign b2.T_DATA = td_v[2];
    assign b0.MDIO_IN = mdio_in;
    assign b1.MDIO_IN = mdio_in;
    assign b2.MDIO_IN = mdio_in;

    mdio_controller #(.DIV_HALF(2)) u0 (.CLK(CLK), .RESET(RESET), .bus(b0));
    mdio_controller #(.DIV_HALF(1)) u1 (.CLK(CLK), .RESET(RESET), .bus(b1));
    mdio_controller #(.DIV_HALF(5)) u2 (.CLK(CLK), .RESET(RESET), .bus(b2));

    logic        mdc_s, out_s, oe_s, busy_s, rdy_s;
    logic [15:0] rd_s;
    always_comb begin
        mdc_s  = (sel == 0) ? b0.MDC : (sel == 1) ? b1.MDC : b2.MDC;
        out_s  = (sel == 0) ? b0.MDIO_OUT : (sel == 1) ? b1.MDIO_OUT : b2.MDIO_OUT;
        oe_s   = (sel == 0) ? b0.MDIO_OE : (sel == 1) ? b1.MDIO_OE : b2.MDIO_OE;
        busy_s = (sel == 0) ? b0.BUSY : (sel == 1) ? b1.BUSY : b2.BUSY;
        rdy_s  = (sel == 0) ? b0.DATA_RDY : (sel == 1) ? b1.DATA_RDY : b2.DATA_RDY;
        rd_s   = (sel == 0) ? b0.RD_DATA : (sel == 1) ? b1.RD_DATA : b2.RD_DATA;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame on instance s; inj>0 pulses a competing start at that cycle.
    task automatic run_frame(input int s, input logic [31:0] td,
                             input logic [15:0] phy, input int inj);
        int dh, nb, lim, cyc, rises, last_rise, hi, per_bad;
        int busy_w, rdy_n, post, idx, b, extra;
        logic rd, prev, eo, eoe;
        logic [15:0] rd_before;
        dh = (s == 0) ? 2 : (s == 1) ? 1 : 5;
        nb = PRE + 32;
        lim = nb * 2 * dh + 20;
        rd = (td[29:28] == 2'b10);
        sel = s;
        rd_before = rd_m[s];
        @(negedge CLK);
        start_v[s] = 1'b1;
        td_v[s] = td;
        @(negedge CLK);
        start_v[s] = 1'b0;
        td_v[s] = $urandom;
        cyc = 0; rises = 0; last_rise = -1; hi = 0; per_bad = 0;
        busy_w = 0; rdy_n = 0; post = 0; prev = 1'b0;
        while (post < 3 && cyc < lim) begin
            if (busy_s) busy_w++;
            if (rdy_s) rdy_n++;
            if (mdc_s) hi++;
            if (mdc_s && !prev) begin
                if (rises < PRE) begin
                    eo = 1'b1;
                    eoe = 1'b1;
                end else begin
                    b = 31 - (rises - PRE);
                    eoe = !(rd && b <= 17);
                    eo = eoe ? td[b] : 1'b0;
                end
                if (rises < nb) begin
                    chk($sformatf("s%0d_out_bit%0d", s, rises), 32'(out_s), 32'(eo));
                    chk($sformatf("s%0d_oe_bit%0d", s, rises), 32'(oe_s), 32'(eoe));
                end
                if (last_rise >= 0 && cyc - last_rise != 2 * dh) per_bad++;
                last_rise = cyc;
                rises++;
            end
            prev = mdc_s;
            if (!busy_s) post++;
            idx = rises - PRE - 16;
            if (idx >= 0 && idx < 16) mdio_in = phy[15 - idx];
            else mdio_in = 1'($urandom);
            if (inj > 0 && cyc == inj) begin
                start_v[s] = 1'b1;
                td_v[s] = ~td;
            end else begin
                start_v[s] = 1'b0;
            end
            @(negedge CLK);
            cyc++;
        end
        if (rd) rd_m[s] = phy;
        chk($sformatf("s%0d_timeout", s), 32'(post), 32'd3);
        chk($sformatf("s%0d_busy_width", s), 32'(busy_w), 32'(nb * 2 * dh + 1));
        chk($sformatf("s%0d_mdc_rises", s), 32'(rises), 32'(nb));
        chk($sformatf("s%0d_mdc_period", s), 32'(per_bad), 32'd0);
        chk($sformatf("s%0d_mdc_high", s), 32'(hi), 32'(nb * dh));
        chk($sformatf("s%0d_rdy_pulses", s), 32'(rdy_n), rd ? 32'd1 : 32'd0);
        chk($sformatf("s%0d_rd_data", s), 32'(rd_s), 32'(rd_m[s]));
        if (!rd) chk($sformatf("s%0d_rd_kept", s), 32'(rd_s), 32'(rd_before));
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy_s || mdc_s || oe_s) extra++;
            @(negedge CLK);
        end
        chk($sformatf("s%0d_idle_quiet", s), 32'(extra), 32'd0);
    endtask

    initial begin
        logic [31:0] td;
        int rdy_seen;
        start_v = 3'b000;
        for (int i = 0; i < 3; i++) begin
            td_v[i] = 32'd0;
            rd_m[i] = 16'd0;
        end
        mdio_in = 1'b0;
        #1;
        chk("rst_mdc", 32'(b0.MDC), 32'd0);
        chk("rst_out", 32'(b0.MDIO_OUT), 32'd0);
        chk("rst_oe", 32'(b0.MDIO_OE), 32'd0);
        chk("rst_rd", 32'(b0.RD_DATA), 32'd0);
        chk("rst_rdy", 32'(b0.DATA_RDY), 32'd0);
        chk("rst_busy", 32'(b0.BUSY), 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        chk("idle_mdc_div1", 32'(b1.MDC), 32'd0);
        chk("idle_mdc_div5", 32'(b2.MDC), 32'd0);

        run_frame(0, 32'h508EABCD, 16'h0000, 60);
        run_frame(0, 32'h608E0000, 16'h1234, 0);
        run_frame(0, 32'h608E0000, 16'hC3A5, 45);
        for (int k = 0; k < 4; k++) begin
            td = $urandom;
            td[31:30] = 2'b01;
            if (k < 2) td[29:28] = 2'b10;
            run_frame(0, td, 16'($urandom), 0);
        end

        // abort a read frame with reset; it must leave no trace
        sel = 0;
        @(negedge CLK);
        start_v[0] = 1'b1;
        td_v[0] = 32'h608E0000;
        @(negedge CLK);
        start_v[0] = 1'b0;
        repeat (40) @(negedge CLK);
        RESET = 1'b0;
        rd_m[0] = 16'd0;
        #1;
        chk("abort_mdc", 32'(b0.MDC), 32'd0);
        chk("abort_out", 32'(b0.MDIO_OUT), 32'd0);
        chk("abort_oe", 32'(b0.MDIO_OE), 32'd0);
        chk("abort_rd", 32'(b0.RD_DATA), 32'd0);
        chk("abort_busy", 32'(b0.BUSY), 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 140; i++) begin
            if (b0.DATA_RDY || b0.BUSY) rdy_seen++;
            @(negedge CLK);
        end
        chk("abort_no_resume", 32'(rdy_seen), 32'd0);
        run_frame(0, 32'h608E0000, 16'hBEEF, 0);

        run_frame(1, 32'h508EABCD, 16'h0000, 20);
        run_frame(1, 32'h6A5E0000, 16'h5A0F, 0);
        run_frame(2, 32'h508EABCD, 16'h0000, 0);
        run_frame(2, 32'h6123FFFF, 16'h8001, 100);
        run_frame(2, 32'h7FFFFFFF, 16'hFFFF, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mdio_controller.md
Name: mdio_controller

Overview:
- MDIO management-side initiator (station). Generates MDC from the system clock and serializes one 32-bit Clause-22 frame per request onto MDIO_OUT/MDIO_OE.
- On read frames, releases the bus after the register address and deserializes 16 data bits from MDIO_IN.
- Sits between the host register interface and the PHY-side MDIO peripheral.

Parameters:
- DIV_HALF, 2, CLK cycles per MDC half-period (MDC period = 2*DIV_HALF CLK). Legal values are 1 to 255.

Ports:
- CLK  input  1  system clock; all logic is on its rising edge.
- RESET  input  1  reset, asynchronous, active-low.
- MDIO_START  input  1  one-CLK request pulse; sampled only in IDLE.
- T_DATA  input  32  frame: [31:30] ST, [29:28] OP, [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] DATA.
- MDIO_IN  input  1  serial data from the PHY (read data phase).
- MDC  output  1  management clock.
- MDIO_OUT  output  1  serial data to the PHY, MSB first.
- MDIO_OE  output  1  1 means the controller drives MDIO.
- RD_DATA  output  16  last read result.
- DATA_RDY  output  1  one-CLK pulse when RD_DATA is updated.
- BUSY  output  1  high while a frame is in progress.

Behaviour:
- Reset (async, RESET=0): MDC=0, MDIO_OUT=0, MDIO_OE=0, RD_DATA=0, DATA_RDY=0, BUSY=0, state=IDLE, bit counter=31, divider=0.
- Reset asserted mid-frame aborts the frame immediately. No DATA_RDY pulse is produced.
- States: IDLE -> [PREAMBLE] -> FRAME -> DONE -> IDLE.
- IDLE:
  - MDC held 0; MDIO_OE=0.
  - On MDIO_START=1: latch T_DATA into the shift register, latch is_read = (OP==2'b10), set BUSY=1, go to PREAMBLE if enabled, otherwise FRAME.
- Bit timing:
  - Each bit occupies one MDC period: DIV_HALF CLK with MDC low, then DIV_HALF CLK with MDC high.
  - MDIO_OUT/MDIO_OE change only at the start of the low phase, so they are stable at every MDC rising edge.
  - The first bit is presented in the CLK cycle after the start is accepted.
- FRAME, bit counter 31 down to 0:
  - Bits 31..18: MDIO_OE=1, MDIO_OUT = T_DATA[bit].
  - Write (is_read=0): bits 17..0 are also driven from T_DATA.
  - Read (is_read=1): MDIO_OE=0 and MDIO_OUT=0 for bits 17..0.
  - Read data capture: for bits 15..0, MDIO_IN is sampled on the CLK edge where MDC rises and is shifted into an internal register, MSB first.
  - OP values 00 and 11 are treated as writes.
- DONE:
  - Entered after the high phase of bit 0 completes; MDC returns to 0 and MDIO_OE=0.
  - Read: RD_DATA takes the captured value and DATA_RDY=1 for exactly this CLK.
  - BUSY=0 in the same CLK. Next state is IDLE.
  - Back-to-back starts are possible: a new MDIO_START is accepted one CLK after DONE.
- MDIO_START while BUSY=1 is ignored. T_DATA changes after acceptance have no effect.
- Write-only frames never change RD_DATA.
- Frame latency without preamble: start accepted -> DONE = 32*2*DIV_HALF + 1 CLK.

Optional Feature:
- Macro MDIO_PREAMBLE_EN.
- Defined: PREAMBLE state sends 32 bits of MDIO_OUT=1 with MDIO_OE=1, using the same bit timing as FRAME, before bit 31 of the frame. Latency grows by 32*2*DIV_HALF CLK.
- Undefined: the PREAMBLE state is not built and FRAME starts directly.

Test Plan:
- Reset: hold RESET=0 mid-frame, release -> all outputs 0, BUSY=0; the next frame is accepted normally.
- Write (DIV_HALF=2, preamble off), T_DATA=32'h508EABCD:
  - MDIO_OUT sampled at the 32 MDC rising edges reproduces 32'h508EABCD, MDIO_OE=1 throughout.
  - BUSY falls 129 CLK after acceptance; DATA_RDY stays 0; RD_DATA unchanged.
- Read, T_DATA=32'h608E0000, PHY model drives 16'h1234 on data bits:
  - MDIO_OE=1 for 14 bits, then 0 for 18 bits.
  - RD_DATA=16'h1234 with a single-cycle DATA_RDY pulse.
- Busy rejection: pulse MDIO_START with different T_DATA during a frame -> the frame in progress is unaffected and no second frame runs.
- Divider: DIV_HALF=1 and DIV_HALF=5 -> MDC period = 2 and 10 CLK, 50% duty cycle, MDC=0 in IDLE.
- MDIO_PREAMBLE_EN defined: write frame -> 32 ones with OE=1, then 32'h508EABCD; BUSY width = 64*2*DIV_HALF+1 CLK.
